// File: rtl/kb_event_ctrl.sv
// kb_event_ctrl
//   Decodes the PS/2 set-2 byte stream (make / F0 break / E0 extended) into
//   per-key held state and one-cycle press pulses, and generates auto-repeat
//   press pulses for the four direction keys (last pressed direction wins).
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-high reset
//   scan_done_tick in   one-cycle strobe, scan_code valid in that cycle
//   scan_code      in   received byte [7:0]
//   held           out  key currently down [5:0]
//                       (0 left, 1 right, 2 up, 3 down, 4 game_reset, 5 enter)
//   press          out  one-cycle pulse per key event / repeat, same bit order
module kb_event_ctrl #(
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_code,
    output logic [5:0] held,
    output logic [5:0] press
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_M1 = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_M1  = CNT_W'(REPEAT_RATE - 1);

    state_t           state_q, state_d;
    logic [5:0]       held_q, held_d;
    logic [5:0]       press_q, press_d;
    logic [1:0]       active_dir_q, active_dir_d;
    logic             active_vld_q, active_vld_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;

    logic       ev_make, ev_break, ev_ext;
    logic       key_vld;
    logic [2:0] key_idx;
    logic       new_make, new_dir, stop_active, rep_fire;

    // Byte sequencing: decide whether this byte completes a make or a break.
    always_comb begin
        state_d  = state_q;
        ev_make  = 1'b0;
        ev_break = 1'b0;
        ev_ext   = 1'b0;
        if (scan_done_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_code == 8'hF0)      state_d = S_BREAK;
                    else if (scan_code == 8'hE0) state_d = S_EXT;
                    else                         ev_make = 1'b1;
                end
                S_BREAK: begin
                    ev_break = 1'b1;
                    state_d  = S_IDLE;
                end
                S_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_d = S_EXT_BREAK;
                    end else if (scan_code != 8'hE0) begin
                        ev_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    ev_break = 1'b1;
                    ev_ext   = 1'b1;
                    state_d  = S_IDLE;
                end
            endcase
        end
    end

    // Key map
    always_comb begin
        key_vld = 1'b0;
        key_idx = 3'd0;
        if (!ev_ext) begin
            case (scan_code)
                8'h1C: begin key_vld = 1'b1; key_idx = 3'd0; end
                8'h23: begin key_vld = 1'b1; key_idx = 3'd1; end
                8'h1D: begin key_vld = 1'b1; key_idx = 3'd2; end
                8'h1B: begin key_vld = 1'b1; key_idx = 3'd3; end
                8'h2D: begin key_vld = 1'b1; key_idx = 3'd4; end
                8'h29: begin key_vld = 1'b1; key_idx = 3'd5; end
                default: ;
            endcase
        end else begin
            case (scan_code)
                8'h6B: begin key_vld = 1'b1; key_idx = 3'd0; end
                8'h74: begin key_vld = 1'b1; key_idx = 3'd1; end
                8'h75: begin key_vld = 1'b1; key_idx = 3'd2; end
                8'h72: begin key_vld = 1'b1; key_idx = 3'd3; end
                default: ;
            endcase
        end
    end

    // Held/press update and repeat scheduling
    always_comb begin
        held_d       = held_q;
        press_d      = '0;
        active_dir_d = active_dir_q;
        active_vld_d = active_vld_q;
        rcnt_d       = rcnt_q;

        // Typematic resends (key already held) are dropped entirely.
        new_make    = ev_make && key_vld && !held_q[key_idx];
        new_dir     = new_make && !key_idx[2];
        stop_active = ev_break && key_vld && !key_idx[2] && active_vld_q &&
                      (active_dir_q == key_idx[1:0]);
        rep_fire    = active_vld_q && (rcnt_q == '0);

        if (active_vld_q) begin
            rcnt_d = rep_fire ? RATE_M1 : rcnt_q - CNT_W'(1);
        end

        if (new_make) begin
            held_d[key_idx]  = 1'b1;
            press_d[key_idx] = 1'b1;
        end
        if (ev_break && key_vld) begin
            held_d[key_idx] = 1'b0;
        end

        // A fresh direction make or a break of the active direction
        // overrides the repeat that would have fired this cycle.
        if (new_dir) begin
            active_dir_d = key_idx[1:0];
            active_vld_d = 1'b1;
            rcnt_d       = DELAY_M1;
        end else if (stop_active) begin
            active_vld_d = 1'b0;
            rcnt_d       = '0;
        end else if (rep_fire) begin
            press_d = press_d | (6'b000001 << active_dir_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            held_q       <= '0;
            press_q      <= '0;
            active_dir_q <= '0;
            active_vld_q <= 1'b0;
            rcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            press_q      <= press_d;
            active_dir_q <= active_dir_d;
            active_vld_q <= active_vld_d;
            rcnt_q       <= rcnt_d;
        end
    end

    assign held  = held_q;
    assign press = press_q;

endmodule

// File: tb/tb_kb_event_ctrl.sv
module tb_kb_event_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_done_tick = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic [5:0] held;
    logic [5:0] press;

    int checks = 0;
    int errors = 0;

    kb_event_ctrl #(
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5),
        .CNT_W       (26)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .scan_done_tick(scan_done_tick),
        .scan_code     (scan_code),
        .held          (held),
        .press         (press)
    );

    always #5 clk = ~clk;

    // Returns 1 ns after the edge that samples the byte, so outputs already
    // reflect the event.
    task automatic tick(input logic [7:0] c);
        @(posedge clk); #1;
        scan_done_tick = 1'b1;
        scan_code      = c;
        @(posedge clk); #1;
        scan_done_tick = 1'b0;
    endtask

    // Cycles until press is non-zero; n = 0 when none appears within max.
    task automatic wait_press(input int max, output int n, output logic [5:0] v);
        n = 0;
        v = '0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            if (press !== 6'b0) begin
                n = i;
                v = press;
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (held !== 6'b000000) begin errors++; $display("FAIL reset_held got %b exp %b", held, 6'b000000); end
        checks++; if (press !== 6'b000000) begin errors++; $display("FAIL reset_press got %b exp %b", press, 6'b000000); end
        reset = 1'b0;
    endtask

    task automatic test_make_and_repeat;
        int n;
        logic [5:0] v;
        tick(8'h1C);
        checks++; if (press !== 6'b000001) begin errors++; $display("FAIL make_press got %b exp %b", press, 6'b000001); end
        checks++; if (held !== 6'b000001) begin errors++; $display("FAIL make_held got %b exp %b", held, 6'b000001); end
        tick(8'h1C);
        checks++; if (press !== 6'b000000) begin errors++; $display("FAIL typematic1 got %b exp %b", press, 6'b000000); end
        tick(8'h1C);
        checks++; if (press !== 6'b000000) begin errors++; $display("FAIL typematic2 got %b exp %b", press, 6'b000000); end
        // 4 cycles already spent in the two typematic ticks
        wait_press(40, n, v);
        checks++; if (n !== 16) begin errors++; $display("FAIL first_repeat_delay got %0d exp %0d", n, 16); end
        checks++; if (v !== 6'b000001) begin errors++; $display("FAIL first_repeat_key got %b exp %b", v, 6'b000001); end
        wait_press(40, n, v);
        checks++; if (n !== 5) begin errors++; $display("FAIL repeat_rate1 got %0d exp %0d", n, 5); end
        checks++; if (v !== 6'b000001) begin errors++; $display("FAIL repeat_key1 got %b exp %b", v, 6'b000001); end
        wait_press(40, n, v);
        checks++; if (n !== 5) begin errors++; $display("FAIL repeat_rate2 got %0d exp %0d", n, 5); end
    endtask

    task automatic test_break;
        int n;
        logic [5:0] v;
        tick(8'hF0);
        tick(8'h1C);
        checks++; if (held !== 6'b000000) begin errors++; $display("FAIL break_held got %b exp %b", held, 6'b000000); end
        checks++; if (press !== 6'b000000) begin errors++; $display("FAIL break_press got %b exp %b", press, 6'b000000); end
        wait_press(30, n, v);
        checks++; if (n !== 0) begin errors++; $display("FAIL break_no_repeat got press %b after %0d cycles exp none", v, n); end
    endtask

    task automatic test_last_wins;
        int n;
        logic [5:0] v;
        tick(8'hE0);
        tick(8'h75);
        checks++; if (press !== 6'b000100) begin errors++; $display("FAIL ext_up_press got %b exp %b", press, 6'b000100); end
        checks++; if (held !== 6'b000100) begin errors++; $display("FAIL ext_up_held got %b exp %b", held, 6'b000100); end
        repeat (10) @(posedge clk);
        #1;
        tick(8'h1B);
        checks++; if (press !== 6'b001000) begin errors++; $display("FAIL down_press got %b exp %b", press, 6'b001000); end
        checks++; if (held !== 6'b001100) begin errors++; $display("FAIL down_held got %b exp %b", held, 6'b001100); end
        wait_press(40, n, v);
        checks++; if (n !== 20) begin errors++; $display("FAIL down_repeat_delay got %0d exp %0d", n, 20); end
        checks++; if (v !== 6'b001000) begin errors++; $display("FAIL down_repeat_key got %b exp %b", v, 6'b001000); end
        wait_press(40, n, v);
        checks++; if (n !== 5 || v !== 6'b001000) begin errors++; $display("FAIL down_repeat2 got %0d/%b exp %0d/%b", n, v, 5, 6'b001000); end
    endtask

    task automatic test_ext_break;
        int n;
        logic [5:0] v;
        tick(8'hE0);
        tick(8'hF0);
        tick(8'h72);
        checks++; if (held !== 6'b000100) begin errors++; $display("FAIL ext_break_held got %b exp %b", held, 6'b000100); end
        wait_press(30, n, v);
        checks++; if (n !== 0) begin errors++; $display("FAIL ext_break_no_repeat got press %b after %0d cycles exp none", v, n); end
    endtask

    task automatic test_game_reset_no_repeat;
        int pulses;
        tick(8'h2D);
        checks++; if (press !== 6'b010000) begin errors++; $display("FAIL game_reset_press got %b exp %b", press, 6'b010000); end
        checks++; if (held !== 6'b010100) begin errors++; $display("FAIL game_reset_held got %b exp %b", held, 6'b010100); end
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (press !== 6'b0) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL game_reset_extra_pulses got %0d exp %0d", pulses, 0); end
    endtask

    task automatic test_reset_mid;
        tick(8'hF0);
        reset = 1'b1;
        #1;
        checks++; if (held !== 6'b000000) begin errors++; $display("FAIL mid_reset_held got %b exp %b", held, 6'b000000); end
        @(posedge clk); #1;
        reset = 1'b0;
        tick(8'h29);
        checks++; if (press !== 6'b100000) begin errors++; $display("FAIL post_reset_press got %b exp %b", press, 6'b100000); end
        checks++; if (held !== 6'b100000) begin errors++; $display("FAIL post_reset_held got %b exp %b", held, 6'b100000); end
    endtask

    task automatic test_collision;
        int n;
        logic [5:0] v;
        tick(8'h1C);
        checks++; if (press !== 6'b000001) begin errors++; $display("FAIL coll_left_press got %b exp %b", press, 6'b000001); end
        // up byte sampled on the 20th edge after the left press: rcnt==0 cycle
        repeat (18) @(posedge clk);
        #1;
        tick(8'h1D);
        checks++; if (press !== 6'b000100) begin errors++; $display("FAIL coll_press got %b exp %b", press, 6'b000100); end
        checks++; if (held !== 6'b100101) begin errors++; $display("FAIL coll_held got %b exp %b", held, 6'b100101); end
        wait_press(40, n, v);
        checks++; if (n !== 20 || v !== 6'b000100) begin errors++; $display("FAIL coll_next_repeat got %0d/%b exp %0d/%b", n, v, 20, 6'b000100); end
    endtask

    initial begin
        test_reset();
        test_make_and_repeat();
        test_break();
        test_last_wins();
        test_ext_break();
        test_game_reset_no_repeat();
        test_reset_mid();
        test_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
